// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
//   registers. It resolves three kinds of events:
//     - multi-cycle data-memory accesses: the whole pipe freezes and MEM/WB
//       takes a bubble every frozen cycle;
//     - load-use hazards: IF and ID hold, and a bubble goes into ID/EX;
//     - taken branches: the instruction in IF/ID is squashed.
//   A memory access that never completes is caught by a timeout counter and
//   parks the block in a sticky error state until reset.
//   A saturating counter records every cycle the PC was held.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous active-low reset
//   ifid_rs1_i     rs1 of the instruction in ID
//   ifid_rs2_i     rs2 of the instruction in ID
//   idex_memread_i instruction in EX is a load
//   idex_rd_i      rd of the instruction in EX
//   branch_taken_i branch resolved taken in ID this cycle
//   exmem_memreq_i instruction in MEM accesses data memory
//   dmem_ready_i   data memory completes the access this cycle
//   pc_we_o, ifid_we_o, idex_we_o, exmem_we_o   pipeline register write enables
//   ifid_flush_o, idex_flush_o, memwb_flush_o   bubble/NOP inserts
//   err_o          sticky memory-timeout error
//   stall_cnt_o    cycles with pc_we_o=0 since reset, saturating
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic             branch_taken_i,
    input  logic             exmem_memreq_i,
    input  logic             dmem_ready_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_we_o,
    output logic             idex_flush_o,
    output logic             exmem_we_o,
    output logic             memwb_flush_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt;
    logic           mem_stall;
    logic           load_use;
    logic           advance;

    assign mem_stall = exmem_memreq_i & ~dmem_ready_i;

    // x0 is never a real dependency, so a load targeting it cannot stall.
    assign load_use = idex_memread_i & (idex_rd_i != 5'd0) &
                      ((idex_rd_i == ifid_rs1_i) | (idex_rd_i == ifid_rs2_i));

    // Cycles in which the pipe is allowed to move. In MEM_WAIT the pending
    // request sits in the frozen EX/MEM register, so exmem_memreq_i is ignored
    // and only dmem_ready_i matters.
    assign advance = ((state == RUN) & ~mem_stall) |
                     ((state == MEM_WAIT) & dmem_ready_i);

    // State register and wait counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                RUN:      if (mem_stall) wait_cnt <= WCW'(1);
                MEM_WAIT: wait_cnt <= dmem_ready_i ? '0 : wait_cnt + WCW'(1);
                default:  wait_cnt <= wait_cnt;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mem_stall) state_nxt = MEM_WAIT;
            MEM_WAIT: begin
                if (dmem_ready_i)
                    state_nxt = RUN;
                else if (wait_cnt == WAIT_LAST)
                    state_nxt = ERR;
            end
            default:  state_nxt = ERR;
        endcase
    end

    // Output logic
    always_comb begin
        pc_we_o       = 1'b1;
        ifid_we_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_we_o     = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_we_o    = 1'b1;
        memwb_flush_o = 1'b0;
        if (!rst_i) begin
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            exmem_we_o    = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            memwb_flush_o = 1'b1;
        end else if (advance) begin
            if (load_use) begin
                // ID holds, so a branch seen this cycle re-resolves next cycle.
                pc_we_o      = 1'b0;
                ifid_we_o    = 1'b0;
                idex_flush_o = 1'b1;
            end else if (branch_taken_i) begin
                ifid_flush_o = 1'b1;
            end
        end else begin
            // Freeze: nothing advances and MEM/WB gets a bubble so the held
            // instruction writes back exactly once, on release.
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            exmem_we_o    = 1'b0;
            memwb_flush_o = 1'b1;
        end
    end

    assign err_o = (state == ERR);

    // Stall-cycle performance counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stall_cnt_o <= '0;
        else if (!pc_we_o && (stall_cnt_o != {CNT_W{1'b1}}))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end

endmodule
